// File: rtl/branch_redirect_ctrl_if.sv
// Branch resolution handshake between EX and the redirect controller,
// plus the redirect/flush outputs and perf counters it returns.
interface branch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic             br_is_branch;
    logic             br_taken;
    logic             br_pred_taken;
    logic [XLEN-1:0]  br_pc;
    logic [XLEN-1:0]  br_imm;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             stall_if;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    modport master (
        output br_valid, br_is_branch, br_taken, br_pred_taken, br_pc, br_imm,
        input  br_ready, redirect_valid, redirect_pc, flush, stall_if,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  br_valid, br_is_branch, br_taken, br_pred_taken, br_pc, br_imm,
        output br_ready, redirect_valid, redirect_pc, flush, stall_if,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch mispredict detection: one-cycle redirect to IF followed by a
// FLUSH_DEPTH-cycle squash/stall of younger stages, with saturating perf counters.
module branch_redirect_ctrl #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_REDIRECT, S_FLUSH} state_t;

    localparam int FCW = (FLUSH_DEPTH > 2) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FCW-1:0] FCNT_LOAD = FCW'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);

    state_t           r_state;
    logic [FCW-1:0]   r_fcnt;
    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             r_flush;
    logic             r_stall_if;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_ready;
    logic             w_br_acc;
    logic             w_mispred;
    logic [XLEN-1:0]  w_target;

    assign w_ready   = (r_state == S_IDLE) & ~rst;
    assign w_br_acc  = bus.br_valid & w_ready & bus.br_is_branch;
    assign w_mispred = w_br_acc & (bus.br_taken ^ bus.br_pred_taken);
    // XLEN-wide adds wrap modulo 2^XLEN; bit 0 of the target is passed through as-is
    assign w_target  = bus.br_taken ? (bus.br_pc + bus.br_imm) : (bus.br_pc + XLEN'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_fcnt           <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush          <= 1'b0;
            r_stall_if       <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispred_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_br_acc && !(&r_branch_cnt))
                        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
                    if (w_mispred) begin
                        if (!(&r_mispred_cnt))
                            r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
                        r_redirect_pc    <= w_target;
                        r_redirect_valid <= 1'b1;
                        r_flush          <= 1'b1;
                        r_stall_if       <= 1'b1;
                        r_state          <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    r_redirect_valid <= 1'b0;
                    if (FLUSH_DEPTH > 1) begin
                        r_fcnt  <= FCNT_LOAD;
                        r_state <= S_FLUSH;
                    end else begin
                        r_flush    <= 1'b0;
                        r_stall_if <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_flush    <= 1'b0;
                        r_stall_if <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt - FCW'(1);
                    end
                end
                default: begin
                    r_redirect_valid <= 1'b0;
                    r_flush          <= 1'b0;
                    r_stall_if       <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.br_ready       = w_ready;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.flush          = r_flush;
    assign bus.stall_if       = r_stall_if;
    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.mispred_cnt    = r_mispred_cnt;
endmodule
